instruction_program_loader: RTL and testbench

- Writer side of the instruction-fetch interface. It loads a program into a 256 x 16 instruction store from an 8-bit byte stream using a valid/ready handshake, with high byte first.
- It then serves 16-bit instructions to the instruction decoder, indexed by the decoder's program counter.
- Any fetch outside the loaded program, or made while not in run mode, returns the unconditional-halt word. This keeps the processor parked until a valid program is present.

---
 rtl/instruction_program_loader.sv | 110 +++++++++++
 tb/tb_instruction_program_loader.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/instruction_program_loader.sv
// rtl/instruction_program_loader.sv - byte-stream program loader and 16-bit instruction fetch port
module instruction_program_loader #(
    parameter int          ADDR_W    = 8,
    parameter int          DEPTH     = 256,
    parameter logic [15:0] HALT_WORD = 16'hE000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              load_end,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [15:0]       instruction,
    output logic [ADDR_W:0]   prog_len,
    output logic              loading,
    output logic              load_error
);

    typedef enum logic [1:0] {IDLE, WAIT_HI, WAIT_LO, RUN} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]     prog_len_q, prog_len_d;
    logic [7:0]          hi_byte_q, hi_byte_d;
    logic                load_error_q, load_error_d;
    logic                mem_we;
    logic                transfer;
    logic [15:0]         mem [DEPTH];

    assign loading  = (state_q == WAIT_HI) || (state_q == WAIT_LO);
    assign rx_ready = loading && !load_end;
    assign transfer = rx_valid && rx_ready;

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        prog_len_d   = prog_len_q;
        hi_byte_d    = hi_byte_q;
        load_error_d = load_error_q;
        mem_we       = 1'b0;
        case (state_q)
            IDLE, RUN: begin
                if (load_start) begin
                    state_d      = WAIT_HI;
                    wr_ptr_d     = '0;
                    prog_len_d   = '0;
                    load_error_d = 1'b0;
                end
            end
            WAIT_HI: begin
                if (load_end) begin
                    state_d = RUN;
                end else if (transfer) begin
                    hi_byte_d = rx_data;
                    state_d   = WAIT_LO;
                end
            end
            WAIT_LO: begin
                // A load ending between the two bytes drops the half word
                if (load_end) begin
                    load_error_d = 1'b1;
                    state_d      = RUN;
                end else if (transfer) begin
                    mem_we     = 1'b1;
                    prog_len_d = {1'b0, wr_ptr_q} + 1'b1;
                    if (wr_ptr_q == LAST_ADDR) begin
                        state_d = RUN;
                    end else begin
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        state_d  = WAIT_HI;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            prog_len_q   <= '0;
            hi_byte_q    <= '0;
            load_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            prog_len_q   <= prog_len_d;
            hi_byte_q    <= hi_byte_d;
            load_error_q <= load_error_d;
        end
    end

    // Store is not reset; stale words stay hidden behind prog_len
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr_q] <= {hi_byte_q, rx_data};
        end
    end

    assign instruction = ((state_q == RUN) && ({1'b0, fetch_addr} < prog_len_q))
                         ? mem[fetch_addr] : HALT_WORD;
    assign prog_len    = prog_len_q;
    assign load_error  = load_error_q;

endmodule

// File: tb/tb_instruction_program_loader.sv
// tb/tb_instruction_program_loader.sv - directed self-checking bench for instruction_program_loader
module tb_instruction_program_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_start;
    logic        load_end;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  fetch_addr;
    logic [15:0] instruction;
    logic [8:0]  prog_len;
    logic        loading;
    logic        load_error;

    int checks = 0;
    int errors = 0;

    instruction_program_loader #(.ADDR_W(8), .DEPTH(256), .HALT_WORD(16'hE000)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .load_end   (load_end),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .fetch_addr (fetch_addr),
        .instruction(instruction),
        .prog_len   (prog_len),
        .loading    (loading),
        .load_error (load_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        int n;
        rx_data  = b;
        rx_valid = 1'b1;
        #1;
        n = 0;
        while (!rx_ready && n < 50) begin
            step();
            n++;
        end
        if (!rx_ready) chk("rx_ready_timeout", {31'b0, rx_ready}, 32'd1);
        step();
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
    endtask

    task automatic pulse_end();
        load_end = 1'b1;
        step();
        load_end = 1'b0;
        rx_valid = 1'b0;
    endtask

    task automatic fetch(input string tag, input logic [7:0] a, input logic [15:0] exp);
        fetch_addr = a;
        #1;
        chk(tag, {16'b0, instruction}, {16'b0, exp});
    endtask

    initial begin
        rst = 1'b1; load_start = 1'b0; load_end = 1'b0;
        rx_data = 8'h00; rx_valid = 1'b0; fetch_addr = 8'h00;
        step(); step();
        chk("rst_rx_ready", {31'b0, rx_ready}, 32'd0);
        chk("rst_loading", {31'b0, loading}, 32'd0);
        chk("rst_instr", {16'b0, instruction}, 32'hE000);
        rst = 1'b0;
        step();
        for (int i = 0; i < 4; i++) fetch("idle_fetch", 8'(i), 16'hE000);
        chk("idle_prog_len", {23'b0, prog_len}, 32'd0);

        // load_end in IDLE is ignored
        pulse_end();
        chk("idle_end_loading", {31'b0, loading}, 32'd0);

        // basic two-word load, valid held high
        pulse_start();
        chk("load_loading", {31'b0, loading}, 32'd1);
        chk("load_rx_ready", {31'b0, rx_ready}, 32'd1);
        send(8'h01); send(8'h05); send(8'h40); send(8'h12);
        rx_valid = 1'b0;
        pulse_end();
        chk("basic_prog_len", {23'b0, prog_len}, 32'd2);
        chk("basic_err", {31'b0, load_error}, 32'd0);
        chk("basic_loading", {31'b0, loading}, 32'd0);
        fetch("basic_f0", 8'd0, 16'h0105);
        fetch("basic_f1", 8'd1, 16'h4012);
        fetch("basic_f2", 8'd2, 16'hE000);

        // gaps on rx_valid, then load_end colliding with a valid byte
        pulse_start();
        begin
            logic [7:0] bytes [4];
            bytes[0] = 8'hA1; bytes[1] = 8'hB2; bytes[2] = 8'hC3; bytes[3] = 8'hD4;
            for (int i = 0; i < 4; i++) begin
                rx_valid = 1'b0;
                repeat ($urandom_range(0, 2)) step();
                send(bytes[i]);
            end
        end
        rx_data = 8'h55; rx_valid = 1'b1; load_end = 1'b1;
        #1;
        chk("end_blocks_ready", {31'b0, rx_ready}, 32'd0);
        step();
        load_end = 1'b0; rx_valid = 1'b0;
        chk("bp_prog_len", {23'b0, prog_len}, 32'd2);
        chk("bp_err", {31'b0, load_error}, 32'd0);
        fetch("bp_f0", 8'd0, 16'hA1B2);
        fetch("bp_f1", 8'd1, 16'hC3D4);
        fetch("bp_f2", 8'd2, 16'hE000);

        // partial word
        pulse_start();
        send(8'hD0);
        rx_valid = 1'b0;
        pulse_end();
        chk("part_err", {31'b0, load_error}, 32'd1);
        chk("part_prog_len", {23'b0, prog_len}, 32'd0);
        fetch("part_f0", 8'd0, 16'hE000);

        // full store, automatic RUN after the last byte
        pulse_start();
        chk("full_err_cleared", {31'b0, load_error}, 32'd0);
        for (int i = 0; i < 256; i++) begin
            send(8'h20);
            send(8'(i));
        end
        rx_valid = 1'b0;
        #1;
        chk("full_prog_len", {23'b0, prog_len}, 32'd256);
        chk("full_rx_ready", {31'b0, rx_ready}, 32'd0);
        chk("full_loading", {31'b0, loading}, 32'd0);
        fetch("full_f255", 8'd255, 16'h20FF);
        fetch("full_f0", 8'd0, 16'h2000);
        fetch("full_f128", 8'd128, 16'h2080);

        // reload over a two-word program
        pulse_start();
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        rx_valid = 1'b0;
        pulse_end();
        chk("pre_reload_len", {23'b0, prog_len}, 32'd2);
        fetch("pre_reload_f1", 8'd1, 16'h3344);
        pulse_start();
        send(8'hE0); send(8'h00);
        rx_valid = 1'b0;
        pulse_end();
        chk("reload_len", {23'b0, prog_len}, 32'd1);
        fetch("reload_f0", 8'd0, 16'hE000);
        fetch("reload_f1_masked", 8'd1, 16'hE000);

        // asynchronous reset mid-load
        pulse_start();
        send(8'h12); send(8'h34); send(8'h56);
        rx_valid = 1'b0;
        chk("mid_len", {23'b0, prog_len}, 32'd1);
        fetch_addr = 8'd0;
        #2;
        rst = 1'b1;
        #1;
        chk("async_loading", {31'b0, loading}, 32'd0);
        chk("async_prog_len", {23'b0, prog_len}, 32'd0);
        chk("async_instr", {16'b0, instruction}, 32'hE000);
        chk("async_rx_ready", {31'b0, rx_ready}, 32'd0);
        step();
        rst = 1'b0;
        step();

        // load_start beats load_end in RUN
        pulse_start();
        send(8'h9A); send(8'hBC);
        rx_valid = 1'b0;
        pulse_end();
        fetch("run_f0", 8'd0, 16'h9ABC);
        load_start = 1'b1; load_end = 1'b1;
        step();
        load_start = 1'b0; load_end = 1'b0;
        chk("start_wins_loading", {31'b0, loading}, 32'd1);
        chk("start_wins_len", {23'b0, prog_len}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
